// File: rtl/aes_pkg.sv
// aes_pkg: shared state encodings, owner IDs and transfer tag for the S-box arbiter
package aes_pkg;
    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_KEY  = 2'd1,
        CTRL_ENC  = 2'd2
    } ctrl_state_t;
    localparam logic OWNER_KEY = 1'b0;
    localparam logic OWNER_ENC = 1'b1;
    typedef struct packed {
        logic valid;
        logic owner;
    } sbox_tag_t;
endpackage

// File: rtl/aes_sbox_route.sv
// aes_sbox_route: aligns each transfer's owner tag with the S-box result and demuxes it
module aes_sbox_route
    import aes_pkg::*;
#(
    parameter int SBOX_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        xfer_valid,
    input  logic        xfer_owner,
    input  logic [31:0] new_sboxw,
    output logic        tag_valid,
    output logic        key_valid,
    output logic [31:0] key_new_sboxw,
    output logic        enc_valid,
    output logic [31:0] enc_new_sboxw
);
    sbox_tag_t tag_d, tag_q, tag;

    // The flop exists for both latencies; a combinational S-box simply bypasses it.
    always_comb begin
        tag_d = '{valid: xfer_valid, owner: xfer_owner};
        tag = (SBOX_LATENCY == 0) ? tag_d : tag_q;
        tag_valid = tag.valid;
        key_valid = tag.valid & (tag.owner == OWNER_KEY);
        enc_valid = tag.valid & (tag.owner == OWNER_ENC);
        key_new_sboxw = key_valid ? new_sboxw : '0;
        enc_new_sboxw = enc_valid ? new_sboxw : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) tag_q <= '0;
        else tag_q <= tag_d;
    end
endmodule

// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter: round-robin sharing of one 32-bit S-box between key expansion and encipher
module aes_sbox_arbiter
    import aes_pkg::*;
#(
    parameter int SBOX_LATENCY = 1,
    parameter int MAX_BURST    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_req,
    input  logic [31:0] key_sboxw,
    output logic        key_grant,
    output logic        key_valid,
    output logic [31:0] key_new_sboxw,
    input  logic        enc_req,
    input  logic [31:0] enc_sboxw,
    output logic        enc_grant,
    output logic        enc_valid,
    output logic [31:0] enc_new_sboxw,
    output logic [31:0] sboxw,
    input  logic [31:0] new_sboxw,
    output logic        busy
);
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    ctrl_state_t state_q, state_d, other_state;
    logic        last_owner_q, last_owner_d;
    logic [3:0]  burst_ctr_q, burst_ctr_d;
    logic        cur_owner, own_req, oth_req, xfer, tag_valid;

    always_comb begin
        state_d = state_q;
        last_owner_d = last_owner_q;
        burst_ctr_d = burst_ctr_q;
        cur_owner = (state_q == CTRL_ENC) ? OWNER_ENC : OWNER_KEY;
        own_req = (cur_owner == OWNER_ENC) ? enc_req : key_req;
        oth_req = (cur_owner == OWNER_ENC) ? key_req : enc_req;
        other_state = (cur_owner == OWNER_ENC) ? CTRL_KEY : CTRL_ENC;
        xfer = (state_q != CTRL_IDLE) & own_req;
        if (state_q == CTRL_IDLE) begin
            if (key_req & enc_req) state_d = (last_owner_q == OWNER_KEY) ? CTRL_ENC : CTRL_KEY;
            else if (key_req) state_d = CTRL_KEY;
            else if (enc_req) state_d = CTRL_ENC;
        end else if (!own_req) begin
            state_d = oth_req ? other_state : CTRL_IDLE;
        end else if (oth_req && burst_ctr_q == BURST_LAST) begin
            state_d = other_state;
        end
        // Counter saturates so a late-arriving competitor gets the S-box on its first request.
        if (state_d != state_q) begin
            burst_ctr_d = '0;
            if (state_q != CTRL_IDLE) last_owner_d = cur_owner;
        end else if (state_q != CTRL_IDLE && burst_ctr_q != BURST_LAST) begin
            burst_ctr_d = burst_ctr_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CTRL_IDLE;
            last_owner_q <= OWNER_ENC;
            burst_ctr_q <= '0;
        end else begin
            state_q <= state_d;
            last_owner_q <= last_owner_d;
            burst_ctr_q <= burst_ctr_d;
        end
    end

    assign key_grant = (state_q == CTRL_KEY);
    assign enc_grant = (state_q == CTRL_ENC);
    assign sboxw = key_grant ? key_sboxw : enc_grant ? enc_sboxw : '0;
    assign busy = (state_q != CTRL_IDLE) | tag_valid;

    aes_sbox_route #(.SBOX_LATENCY(SBOX_LATENCY)) u_route (
        .clk           (clk),
        .reset         (reset),
        .xfer_valid    (xfer),
        .xfer_owner    (cur_owner),
        .new_sboxw     (new_sboxw),
        .tag_valid     (tag_valid),
        .key_valid     (key_valid),
        .key_new_sboxw (key_new_sboxw),
        .enc_valid     (enc_valid),
        .enc_new_sboxw (enc_new_sboxw)
    );
endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// tb_aes_sbox_arbiter: directed checks of arbitration, bursts and result routing for both S-box latencies
module tb_aes_sbox_arbiter;
    localparam logic [31:0] KW = 32'h00010203;
    localparam logic [31:0] EW = 32'h53535353;
    localparam logic [31:0] KS = 32'h637c777b;
    localparam logic [31:0] ES = 32'hedededed;

    logic clk = 1'b0;
    logic reset, key_req, enc_req;
    logic [31:0] key_sboxw, enc_sboxw;
    logic key_grant1, key_valid1, enc_grant1, enc_valid1, busy1;
    logic [31:0] key_new1, enc_new1, sboxw1, new_sboxw1;
    logic key_grant0, key_valid0, enc_grant0, enc_valid0, busy0;
    logic [31:0] key_new0, enc_new0, sboxw0, new_sboxw0;
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            b = b >> 1;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    // Reference S-box: multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox8(input logic [7:0] x);
        logic [7:0] r;
        logic [15:0] d;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        d = {r, r};
        return r ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    function automatic logic [31:0] sbox32(input logic [31:0] w);
        return {sbox8(w[31:24]), sbox8(w[23:16]), sbox8(w[15:8]), sbox8(w[7:0])};
    endfunction

    always @(posedge clk) new_sboxw1 <= sbox32(sboxw1);
    assign new_sboxw0 = sbox32(sboxw0);

    aes_sbox_arbiter #(.SBOX_LATENCY(1), .MAX_BURST(4)) u_lat1 (
        .clk(clk), .reset(reset),
        .key_req(key_req), .key_sboxw(key_sboxw), .key_grant(key_grant1),
        .key_valid(key_valid1), .key_new_sboxw(key_new1),
        .enc_req(enc_req), .enc_sboxw(enc_sboxw), .enc_grant(enc_grant1),
        .enc_valid(enc_valid1), .enc_new_sboxw(enc_new1),
        .sboxw(sboxw1), .new_sboxw(new_sboxw1), .busy(busy1)
    );

    aes_sbox_arbiter #(.SBOX_LATENCY(0), .MAX_BURST(4)) u_lat0 (
        .clk(clk), .reset(reset),
        .key_req(key_req), .key_sboxw(key_sboxw), .key_grant(key_grant0),
        .key_valid(key_valid0), .key_new_sboxw(key_new0),
        .enc_req(enc_req), .enc_sboxw(enc_sboxw), .enc_grant(enc_grant0),
        .enc_valid(enc_valid0), .enc_new_sboxw(enc_new0),
        .sboxw(sboxw0), .new_sboxw(new_sboxw0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic kr, input logic er);
        @(posedge clk);
        #1;
        reset = rst;
        key_req = kr;
        enc_req = er;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        key_req = 1'b0;
        enc_req = 1'b0;
        key_sboxw = KW;
        enc_sboxw = EW;
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 1, 1);
        chk("rst_key_grant", key_grant1, 0);
        chk("rst_enc_grant", enc_grant1, 0);
        chk("rst_key_valid", key_valid1, 0);
        chk("rst_enc_valid", enc_valid1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_sboxw", sboxw1, 0);
        chk("rst_key_new", key_new1, 0);
        chk("rst_enc_new", enc_new1, 0);
        for (int c = 1; c <= 12; c++) begin
            logic kg;
            kg = (c <= 4) || (c >= 9);
            step(0, 1, 1);
            chk($sformatf("c%0d_key_grant", c), key_grant1, 32'(kg));
            chk($sformatf("c%0d_enc_grant", c), enc_grant1, 32'(!kg));
            chk($sformatf("c%0d_sboxw", c), sboxw1, kg ? KW : EW);
            chk($sformatf("c%0d_busy", c), busy1, 1);
            chk($sformatf("c%0d_lat0_key_valid", c), key_valid0, 32'(kg));
            chk($sformatf("c%0d_lat0_enc_new", c), enc_new0, kg ? 32'h0 : ES);
            if (c == 5) begin
                chk("c5_key_valid", key_valid1, 1);
                chk("c5_key_new", key_new1, KS);
                chk("c5_enc_valid", enc_valid1, 0);
            end
            if (c == 9) begin
                chk("c9_enc_valid", enc_valid1, 1);
                chk("c9_enc_new", enc_new1, ES);
                chk("c9_key_valid", key_valid1, 0);
                chk("c9_key_new", key_new1, 0);
            end
        end
        step(0, 0, 1);
        chk("c13_enc_grant", enc_grant1, 1);
        chk("c13_key_valid", key_valid1, 1);
        chk("c13_key_new", key_new1, KS);
        step(0, 0, 1);
        chk("c14_enc_grant", enc_grant1, 1);
        chk("c14_enc_new", enc_new1, ES);
        step(0, 0, 0);
        chk("c15_enc_grant", enc_grant1, 1);
        chk("c15_enc_valid", enc_valid1, 1);
        chk("c15_busy", busy1, 1);
        chk("c15_lat0_no_xfer", enc_valid0, 0);
        step(0, 0, 0);
        chk("c16_key_grant", key_grant1, 0);
        chk("c16_enc_grant", enc_grant1, 0);
        chk("c16_sboxw", sboxw1, 0);
        chk("c16_busy", busy1, 0);
        chk("c16_enc_valid", enc_valid1, 0);
        step(0, 1, 0);
        chk("c17_grant_latency", key_grant1, 0);
        step(0, 1, 0);
        chk("c18_key_grant", key_grant1, 1);
        chk("c18_sboxw", sboxw1, KW);
        chk("c18_key_valid", key_valid1, 0);
        step(1, 1, 0);
        chk("c19_key_valid", key_valid1, 1);
        chk("c19_key_new", key_new1, KS);
        chk("c19_enc_valid", enc_valid1, 0);
        chk("c19_enc_new", enc_new1, 0);
        step(0, 0, 0);
        chk("c20_key_grant", key_grant1, 0);
        chk("c20_enc_grant", enc_grant1, 0);
        chk("c20_key_valid", key_valid1, 0);
        chk("c20_enc_valid", enc_valid1, 0);
        chk("c20_key_new", key_new1, 0);
        chk("c20_sboxw", sboxw1, 0);
        chk("c20_busy", busy1, 0);
        chk("c20_lat0_key_valid", key_valid0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
